// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath.
//   Instr      : instruction register fields [31:12] (datapath -> controller)
//   ALUFlags   : {N,Z,C,V} from the ALU, current cycle (datapath -> controller)
//   remaining  : mux selects, write enables and debug state (controller -> datapath)
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic         RegWrite;
  logic [1:0]   RegSrc;
  logic [1:0]   ImmSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ALUControl;
  logic [1:0]   ResultSrc;
  logic [3:0]   Flags;
  logic [3:0]   State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Flags, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, Flags, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control unit for a multicycle ARMv4-subset datapath (ADD/SUB/AND/ORR/CMP/TST, LDR/STR, B).
// Holds the instruction FSM, ALU decoder, NZCV flag register and conditional-execution latch.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (FSM -> FETCH, flags and condex cleared)
//   bus   : controller side of multicycle_controller_if (Instr/ALUFlags in, controls out)
// All outputs are Moore decodes of state, Instr and condex_q; none depend on ALUFlags.
module multicycle_controller (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       imm_bit, s_bit;
  logic       unused_rn;

  assign cond    = bus.Instr[31:28];
  assign op      = bus.Instr[27:26];
  assign imm_bit = bus.Instr[25];
  assign cmd     = bus.Instr[24:21];
  assign s_bit   = bus.Instr[20];
  assign rd      = bus.Instr[15:12];
  assign unused_rn = ^bus.Instr[19:16];

  // Condition evaluation against the architectural flags.
  logic cond_ok;
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = fc & ~fz;
      4'b1001: cond_ok = ~fc | fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = ~fz & (fn == fv);
      4'b1101: cond_ok = fz | (fn != fv);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // ALU decoder; only data-processing encodings (Op 00) can assert no_write.
  logic [1:0] dp_ctrl, flag_w;
  logic       no_write;

  always_comb begin
    dp_ctrl  = 2'b00;
    flag_w   = 2'b00;
    no_write = 1'b0;
    if (op == 2'b00) begin
      case (cmd)
        4'b0100: begin dp_ctrl = 2'b00; flag_w = {s_bit, s_bit}; end
        4'b0010: begin dp_ctrl = 2'b01; flag_w = {s_bit, s_bit}; end
        4'b0000: begin dp_ctrl = 2'b10; flag_w = {s_bit, 1'b0}; end
        4'b1100: begin dp_ctrl = 2'b11; flag_w = {s_bit, 1'b0}; end
        4'b1010: begin dp_ctrl = 2'b01; flag_w = {s_bit, s_bit}; no_write = 1'b1; end
        4'b1000: begin dp_ctrl = 2'b10; flag_w = {s_bit, 1'b0};  no_write = 1'b1; end
        default: begin dp_ctrl = 2'b00; flag_w = 2'b00;          no_write = 1'b1; end
      endcase
    end
  end

  // Next state.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = StDecode;
      StDecode: begin
        case (op)
          2'b00:   state_d = imm_bit ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = s_bit ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecR,
      StExecI:    state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Per-state control decode.
  logic       exec, reg_w, mem_w;
  logic       ir_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;

  always_comb begin
    exec       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StDecode: begin
        // PC+8 for R15 operand reads.
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StMemAdr:   alu_src_b = 2'b01;
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      StMemWrite: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      StExecR:    exec = 1'b1;
      StExecI: begin
        exec      = 1'b1;
        alu_src_b = 2'b01;
      end
      StAluWb:    reg_w = 1'b1;
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
      end
      default: ;
    endcase
  end

  // Flag and condition latch updates.
  always_comb begin
    flags_d = flags_q;
    if (exec && condex_q) begin
      if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
    condex_d = (state_q == StDecode) ? cond_ok : condex_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = exec ? dp_ctrl : 2'b00;
  assign bus.RegWrite   = reg_w & condex_q & ~no_write;
  assign bus.MemWrite   = mem_w & condex_q;
  assign bus.PCWrite    = (state_q == StFetch) |
                          (condex_q & ((state_q == StBranch) | (reg_w & (rd == 4'hF))));
  assign bus.ImmSrc     = (op == 2'b11) ? 2'b00 : op;
  assign bus.RegSrc     = {(op == 2'b01) & ~s_bit, op == 2'b10};
  assign bus.Flags      = flags_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.Instr = 20'h00000;
    bus.ALUFlags = 4'b0000;
    @(negedge clk);
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL rst_state got=%0d exp=0", bus.State); end
    checks++; if (bus.Flags !== 4'b0000) begin failures++;
      $display("FAIL rst_flags got=%b exp=0000", bus.Flags); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++;
      $display("FAIL rst_regwrite got=%b exp=0", bus.RegWrite); end
    checks++; if (bus.PCWrite !== 1'b1) begin failures++;
      $display("FAIL rst_pcwrite got=%b exp=1", bus.PCWrite); end
    checks++; if (bus.IRWrite !== 1'b1) begin failures++;
      $display("FAIL rst_irwrite got=%b exp=1", bus.IRWrite); end
    checks++; if (bus.MemWrite !== 1'b0) begin failures++;
      $display("FAIL rst_memwrite got=%b exp=0", bus.MemWrite); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_add_imm;
    bus.Instr = 20'hE2802;
    bus.ALUFlags = 4'b0000;
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL add_fetch got=%0d exp=0", bus.State); end
    step();
    checks++; if (bus.State !== 4'd1) begin failures++;
      $display("FAIL add_decode got=%0d exp=1", bus.State); end
    step();
    checks++; if (bus.State !== 4'd7) begin failures++;
      $display("FAIL add_execi got=%0d exp=7", bus.State); end
    checks++; if (bus.ALUSrcB !== 2'b01) begin failures++;
      $display("FAIL add_srcb got=%b exp=01", bus.ALUSrcB); end
    checks++; if (bus.ALUControl !== 2'b00) begin failures++;
      $display("FAIL add_aluctl got=%b exp=00", bus.ALUControl); end
    checks++; if (bus.PCWrite !== 1'b0) begin failures++;
      $display("FAIL add_exec_pcw got=%b exp=0", bus.PCWrite); end
    step();
    checks++; if (bus.State !== 4'd8) begin failures++;
      $display("FAIL add_aluwb got=%0d exp=8", bus.State); end
    checks++; if (bus.RegWrite !== 1'b1) begin failures++;
      $display("FAIL add_regwrite got=%b exp=1", bus.RegWrite); end
    checks++; if (bus.PCWrite !== 1'b0) begin failures++;
      $display("FAIL add_wb_pcw got=%b exp=0", bus.PCWrite); end
    step();
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL add_done got=%0d exp=0", bus.State); end
  endtask

  task automatic test_cmp_branch;
    bus.Instr = 20'hE3500;
    bus.ALUFlags = 4'b0100;
    step(); step();
    checks++; if (bus.ALUControl !== 2'b01) begin failures++;
      $display("FAIL cmp_aluctl got=%b exp=01", bus.ALUControl); end
    step();
    checks++; if (bus.Flags !== 4'b0100) begin failures++;
      $display("FAIL cmp_flags got=%b exp=0100", bus.Flags); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++;
      $display("FAIL cmp_regwrite got=%b exp=0", bus.RegWrite); end
    step();
    bus.ALUFlags = 4'b0000;
    bus.Instr = 20'h0A000;
    step(); step();
    checks++; if (bus.State !== 4'd9) begin failures++;
      $display("FAIL beq_state got=%0d exp=9", bus.State); end
    checks++; if (bus.PCWrite !== 1'b1) begin failures++;
      $display("FAIL beq_pcwrite got=%b exp=1", bus.PCWrite); end
    checks++; if (bus.ImmSrc !== 2'b10) begin failures++;
      $display("FAIL beq_immsrc got=%b exp=10", bus.ImmSrc); end
    step();
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL beq_done got=%0d exp=0", bus.State); end
    bus.Instr = 20'h1A000;
    step(); step();
    checks++; if (bus.PCWrite !== 1'b0) begin failures++;
      $display("FAIL bne_pcwrite got=%b exp=0", bus.PCWrite); end
    step();
    checks++; if (bus.Flags !== 4'b0100) begin failures++;
      $display("FAIL br_flags_kept got=%b exp=0100", bus.Flags); end
  endtask

  task automatic test_cond_suppress;
    bus.Instr = 20'h12902;
    bus.ALUFlags = 4'b1000;
    step(); step(); step();
    checks++; if (bus.State !== 4'd8) begin failures++;
      $display("FAIL sup_state got=%0d exp=8", bus.State); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++;
      $display("FAIL sup_regwrite got=%b exp=0", bus.RegWrite); end
    checks++; if (bus.Flags !== 4'b0100) begin failures++;
      $display("FAIL sup_flags got=%b exp=0100", bus.Flags); end
    step();
    bus.ALUFlags = 4'b0000;
  endtask

  task automatic test_pc_via_alu;
    bus.Instr = 20'hE28FF;
    step(); step();
    checks++; if (bus.PCWrite !== 1'b0) begin failures++;
      $display("FAIL pcalu_exec_pcw got=%b exp=0", bus.PCWrite); end
    step();
    checks++; if (bus.PCWrite !== 1'b1) begin failures++;
      $display("FAIL pcalu_wb_pcw got=%b exp=1", bus.PCWrite); end
    step();
  endtask

  task automatic test_load_store;
    int memw_cnt;
    bus.Instr = 20'hE5901;
    step(); step();
    checks++; if (bus.State !== 4'd2) begin failures++;
      $display("FAIL ldr_memadr got=%0d exp=2", bus.State); end
    checks++; if (bus.ALUSrcB !== 2'b01) begin failures++;
      $display("FAIL ldr_srcb got=%b exp=01", bus.ALUSrcB); end
    step();
    checks++; if (bus.State !== 4'd3) begin failures++;
      $display("FAIL ldr_memread got=%0d exp=3", bus.State); end
    checks++; if (bus.AdrSrc !== 1'b1) begin failures++;
      $display("FAIL ldr_adrsrc got=%b exp=1", bus.AdrSrc); end
    step();
    checks++; if (bus.State !== 4'd4) begin failures++;
      $display("FAIL ldr_memwb got=%0d exp=4", bus.State); end
    checks++; if (bus.ResultSrc !== 2'b01) begin failures++;
      $display("FAIL ldr_ressrc got=%b exp=01", bus.ResultSrc); end
    checks++; if (bus.RegWrite !== 1'b1) begin failures++;
      $display("FAIL ldr_regwrite got=%b exp=1", bus.RegWrite); end
    step();
    bus.Instr = 20'hE5801;
    memw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.MemWrite === 1'b1) memw_cnt++;
      if (i == 3) begin
        checks++; if (bus.State !== 4'd5) begin failures++;
          $display("FAIL str_state got=%0d exp=5", bus.State); end
        checks++; if (bus.RegSrc !== 2'b10) begin failures++;
          $display("FAIL str_regsrc got=%b exp=10", bus.RegSrc); end
      end
      step();
    end
    checks++; if (memw_cnt != 1) begin failures++;
      $display("FAIL str_memw_cycles got=%0d exp=1", memw_cnt); end
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL str_done got=%0d exp=0", bus.State); end
  endtask

  task automatic test_nop;
    bus.Instr = 20'hEC000;
    step(); step();
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL nop_cpi got=%0d exp=0", bus.State); end
  endtask

  task automatic test_reset_mid;
    bus.ALUFlags = 4'b0100;
    bus.Instr = 20'hE3500;  // CMP: leave Z set so reset clearing is visible
    step(); step(); step(); step();
    bus.Instr = 20'hE5901;
    step(); step(); step(); step();
    checks++; if (bus.State !== 4'd4) begin failures++;
      $display("FAIL rmid_pre got=%0d exp=4", bus.State); end
    reset = 1'b1;
    #1;
    checks++; if (bus.State !== 4'd0) begin failures++;
      $display("FAIL rmid_state got=%0d exp=0", bus.State); end
    checks++; if (bus.Flags !== 4'b0000) begin failures++;
      $display("FAIL rmid_flags got=%b exp=0000", bus.Flags); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++;
      $display("FAIL rmid_regwrite got=%b exp=0", bus.RegWrite); end
    checks++; if (bus.PCWrite !== 1'b1) begin failures++;
      $display("FAIL rmid_pcwrite got=%b exp=1", bus.PCWrite); end
    checks++; if (bus.IRWrite !== 1'b1) begin failures++;
      $display("FAIL rmid_irwrite got=%b exp=1", bus.IRWrite); end
    #21;
    reset = 1'b0;
    step();
    checks++; if (bus.State !== 4'd1) begin failures++;
      $display("FAIL rmid_restart got=%0d exp=1", bus.State); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_cmp_branch();
    test_cond_suppress();
    test_pc_via_alu();
    test_load_store();
    test_nop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
